// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and oversampling points.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE   = 0;
  localparam int PAR_EVEN   = 1;
  localparam int PAR_ODD    = 2;
  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 7;

  // Data is zero-extended to 8 bits, which leaves its XOR unchanged.
  function automatic logic calc_parity(input logic [7:0] d, input int mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty flags.
// Push while full and pop while empty are ignored; the head reads 0 while empty.
module uart_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic          full_q, empty_q, do_wr, do_rd;

  assign do_wr  = wr_i && !full_q;
  assign do_rd  = rd_i && !empty_q;
  assign wptr_d = wptr_q + 1'b1;
  assign rptr_d = rptr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_wr) wptr_q <= wptr_d;
      if (do_rd) rptr_q <= rptr_d;
      if (do_wr && !do_rd) begin
        empty_q <= 1'b0;
        full_q  <= (wptr_d == rptr_q);
      end else if (do_rd && !do_wr) begin
        full_q  <= 1'b0;
        empty_q <= (rptr_d == wptr_q);
      end
    end
  end

  assign rdata_o = empty_q ? '0 : mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex 16x-oversampled UART with RX/TX FIFOs, optional parity, sticky errors and RX activity LED.
// Define UART_LOOPBACK_EN to route the TX line into the receiver when loopback = 1.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 326,
  parameter int PARITY  = 0,
  parameter int FIFO_AW = 4,
  parameter int ACT_W   = 25
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic            tx,
  input  logic [DBIT-1:0] w_data,
  input  logic            wr_uart,
  output logic            tx_full,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  input  logic            err_clr,
  output logic            act_led,
  input  logic            loopback
);

  localparam int TW = $clog2(DVSR);
  localparam int SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int NW = $clog2(DBIT);

  logic [TW-1:0]    tick_q, tick_d;
  logic             s_tick;
  logic             rx_src, rx_sync1_q, rx_sync2_q;
  uart_state_e      rx_st_q, tx_st_q;
  logic [SW-1:0]    rx_cnt_q, tx_cnt_q;
  logic [NW-1:0]    rx_n_q, tx_n_q;
  logic [DBIT-1:0]  rx_sh_q, tx_sh_q, tx_head;
  logic             rx_par_q, rx_push_q, tx_par_q, tx_q;
  logic             rx_full, tx_empty, tx_load;
  logic             stop_evt, frame_evt, parity_evt, overrun_evt;
  logic             frame_err_q, parity_err_q, overrun_q;
  logic [ACT_W-1:0] act_q, act_d;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_q : rx;
  assign tx     = loopback ? 1'b1 : tx_q;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign rx_src = rx;
  assign tx     = tx_q;
`endif

  assign s_tick = (tick_q == TW'(DVSR - 1));
  assign tick_d = s_tick ? '0 : tick_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q     <= '0;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
    end else begin
      tick_q     <= tick_d;
      rx_sync1_q <= rx_src;
      rx_sync2_q <= rx_sync1_q;
    end
  end

  // Receiver: start edge re-checked at mid-bit, then every 16 ticks samples mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st_q   <= ST_IDLE;
      rx_cnt_q  <= '0;
      rx_n_q    <= '0;
      rx_sh_q   <= '0;
      rx_par_q  <= 1'b0;
      rx_push_q <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      case (rx_st_q)
        ST_IDLE: if (!rx_sync2_q) begin
          rx_st_q  <= ST_START;
          rx_cnt_q <= '0;
        end
        ST_START: if (s_tick) begin
          if (rx_cnt_q == SW'(START_MID)) begin
            rx_cnt_q <= '0;
            rx_n_q   <= '0;
            rx_st_q  <= rx_sync2_q ? ST_IDLE : ST_DATA;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        ST_DATA: if (s_tick) begin
          if (rx_cnt_q == SW'(OVERSAMPLE - 1)) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_sync2_q, rx_sh_q[DBIT-1:1]};
            if (rx_n_q == NW'(DBIT - 1)) rx_st_q <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            else rx_n_q <= rx_n_q + 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        ST_PAR: if (s_tick) begin
          if (rx_cnt_q == SW'(OVERSAMPLE - 1)) begin
            rx_cnt_q <= '0;
            rx_par_q <= rx_sync2_q;
            rx_st_q  <= ST_STOP;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        ST_STOP: if (s_tick) begin
          if (rx_cnt_q == SW'(SB_TICK - 1)) begin
            rx_st_q   <= ST_IDLE;
            rx_push_q <= 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        default: rx_st_q <= ST_IDLE;
      endcase
    end
  end

  assign stop_evt    = (rx_st_q == ST_STOP) && s_tick && (rx_cnt_q == SW'(SB_TICK - 1));
  assign frame_evt   = stop_evt && !rx_sync2_q;
  assign parity_evt  = stop_evt && (PARITY != PAR_NONE) &&
                       (rx_par_q != calc_parity(8'(rx_sh_q), PARITY));
  assign overrun_evt = rx_push_q && rx_full;

  // Loads only on a tick so every bit, the start bit included, lasts whole ticks.
  assign tx_load = !tx_empty && s_tick &&
                   ((tx_st_q == ST_IDLE) ||
                    ((tx_st_q == ST_STOP) && (tx_cnt_q == SW'(SB_TICK - 1))));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q  <= ST_IDLE;
      tx_cnt_q <= '0;
      tx_n_q   <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      tx_q     <= 1'b1;
    end else if (tx_load) begin
      tx_st_q  <= ST_START;
      tx_cnt_q <= '0;
      tx_sh_q  <= tx_head;
      tx_par_q <= calc_parity(8'(tx_head), PARITY);
      tx_q     <= 1'b0;
    end else if (s_tick) begin
      case (tx_st_q)
        ST_START: if (tx_cnt_q == SW'(OVERSAMPLE - 1)) begin
          tx_cnt_q <= '0;
          tx_n_q   <= '0;
          tx_q     <= tx_sh_q[0];
          tx_st_q  <= ST_DATA;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        ST_DATA: if (tx_cnt_q == SW'(OVERSAMPLE - 1)) begin
          tx_cnt_q <= '0;
          if (tx_n_q == NW'(DBIT - 1)) begin
            tx_st_q <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            tx_q    <= (PARITY != PAR_NONE) ? tx_par_q : 1'b1;
          end else begin
            tx_n_q  <= tx_n_q + 1'b1;
            tx_sh_q <= {1'b0, tx_sh_q[DBIT-1:1]};
            tx_q    <= tx_sh_q[1];
          end
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        ST_PAR: if (tx_cnt_q == SW'(OVERSAMPLE - 1)) begin
          tx_cnt_q <= '0;
          tx_st_q  <= ST_STOP;
          tx_q     <= 1'b1;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        ST_STOP: if (tx_cnt_q == SW'(SB_TICK - 1)) begin
          tx_cnt_q <= '0;
          tx_st_q  <= ST_IDLE;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        default: tx_st_q <= ST_IDLE;
      endcase
    end
  end

  assign act_d = rx_empty ? act_q : act_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      act_q        <= '0;
    end else begin
      frame_err_q  <= frame_evt   || (frame_err_q  && !err_clr);
      parity_err_q <= parity_evt  || (parity_err_q && !err_clr);
      overrun_q    <= overrun_evt || (overrun_q    && !err_clr);
      act_q        <= act_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign act_led    = act_q[ACT_W-1];

  uart_sync_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (wr_uart),
    .wdata_i (w_data),
    .rd_i    (tx_load),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  uart_sync_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (rx_push_q),
    .wdata_i (rx_sh_q),
    .rd_i    (rd_uart),
    .rdata_o (r_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core: 8N1 instance (depth 4, 4-bit activity counter) and an even-parity instance.
module tb_uart_fifo_core;

  localparam int BIT_CLK = 64;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_ferr;
  } rx_vec_t;

  logic       clk = 1'b0;
  logic       reset, rx_drv, lb_sel, err_clr;
  logic [7:0] w_data;
  logic       wr0, wr1, rd0, rd1;
  logic       tx0, tx_full0, rx_empty0, ferr0, perr0, ovr0, led0;
  logic       tx1, tx_full1, rx_empty1, ferr1, perr1, ovr1, led1, rx1;
  logic [7:0] r_data0, r_data1;

  logic [7:0] sb_q [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign rx1 = lb_sel ? tx1 : rx_drv;

  uart_fifo_core #(.DBIT(8), .SB_TICK(16), .DVSR(4), .PARITY(0), .FIFO_AW(2), .ACT_W(4)) dut0 (
    .clk(clk), .reset(reset), .rx(rx_drv), .tx(tx0), .w_data(w_data), .wr_uart(wr0),
    .tx_full(tx_full0), .rd_uart(rd0), .r_data(r_data0), .rx_empty(rx_empty0),
    .frame_err(ferr0), .parity_err(perr0), .overrun(ovr0), .err_clr(err_clr),
    .act_led(led0), .loopback(1'b0)
  );

  uart_fifo_core #(.DBIT(8), .SB_TICK(16), .DVSR(4), .PARITY(1), .FIFO_AW(4), .ACT_W(25)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .tx(tx1), .w_data(w_data), .wr_uart(wr1),
    .tx_full(tx_full1), .rd_uart(rd1), .r_data(r_data1), .rx_empty(rx_empty1),
    .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1), .err_clr(err_clr),
    .act_led(led1), .loopback(1'b0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr_errors();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic write_byte(input bit which, input logic [7:0] d);
    w_data = d;
    if (which) wr1 = 1'b1; else wr0 = 1'b1;
    @(negedge clk);
    wr0 = 1'b0;
    wr1 = 1'b0;
  endtask

  // A low stop bit is released after 3/4 of the bit so the line is idle before a new start check.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic use_par, input logic pbit);
    rx_drv = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (use_par) begin
      rx_drv = pbit;
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop) begin
      rx_drv = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      rx_drv = 1'b0;
      repeat (48) @(negedge clk);
      rx_drv = 1'b1;
      repeat (16) @(negedge clk);
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic pop_check(input bit which, input string name);
    logic [7:0] exp;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard has 0 entries, required at least 1", name);
      return;
    end
    exp = sb_q.pop_front();
    check({name, "_avail"}, which ? rx_empty1 : rx_empty0, 1'b0);
    check(name, which ? r_data1 : r_data0, exp);
    if (which) rd1 = 1'b1; else rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    rd1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx_vec_t    vt [4];
    logic [7:0] ov [5];
    logic [9:0] fr;
    int         good, cnt, w;
    bit         exp_ovr;

    vt[0] = '{8'h55, 1'b0, 1'b1};
    vt[1] = '{8'h00, 1'b1, 1'b0};
    vt[2] = '{8'hFF, 1'b1, 1'b0};
    vt[3] = '{8'hC3, 1'b0, 1'b1};
    ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33; ov[3] = 8'h44; ov[4] = 8'h55;

    reset = 1'b1; rx_drv = 1'b1; lb_sel = 1'b0; err_clr = 1'b0;
    w_data = '0; wr0 = 1'b0; wr1 = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
    do_reset();

    check("rst_tx", tx0, 1'b1);
    check("rst_rx_empty", rx_empty0, 1'b1);
    check("rst_tx_full", tx_full0, 1'b0);
    check("rst_r_data", r_data0, 8'h00);
    check("rst_errors", {ferr0, perr0, ovr0}, 3'b000);
    check("rst_act_led", led0, 1'b0);

    // TX waveform of 0xA5: start, LSB-first data, stop; each bit exactly 64 clk.
    write_byte(0, 8'hA5);
    w = 0;
    while (tx0 && w < 200) begin @(negedge clk); w++; end
    check("tx_start_seen", tx0, 1'b0);
    fr = {1'b1, 8'hA5, 1'b0};
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      good = 0;
      for (int j = 0; j < BIT_CLK; j++) begin
        if (tx0 === fr[k]) good++;
        if (tx_full0 !== 1'b0) cnt++;
        @(negedge clk);
      end
      check($sformatf("tx_bit%0d_samples", k), good, BIT_CLK);
    end
    check("tx_full_cycles", cnt, 0);
    check("tx_idle_after", tx0, 1'b1);

    // Received frames, including bad stop bits, from the vector table.
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(vt[i].d);
      send_frame(vt[i].d, vt[i].stop, 1'b0, 1'b0);
      check($sformatf("rx%0d_frame_err", i), ferr0, vt[i].exp_ferr);
      check($sformatf("rx%0d_parity_err", i), perr0, 1'b0);
      pop_check(0, $sformatf("rx%0d_data", i));
      clr_errors();
      check($sformatf("rx%0d_ferr_cleared", i), ferr0, 1'b0);
    end
    check("rx_drained", rx_empty0, 1'b1);

    // Five frames into a depth-4 FIFO with no reads.
    exp_ovr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (sb_q.size() >= 4) exp_ovr = 1'b1;
      else sb_q.push_back(ov[i]);
      send_frame(ov[i], 1'b1, 1'b0, 1'b0);
      check($sformatf("ovr_f%0d", i), ovr0, exp_ovr);
    end
    for (int i = 0; i < 4; i++) pop_check(0, $sformatf("ovr_pop%0d", i));
    check("ovr_fifo_empty", rx_empty0, 1'b1);
    clr_errors();
    check("ovr_cleared", ovr0, 1'b0);

    // A 3-tick low pulse is a glitch, not a start bit.
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_rx_empty", rx_empty0, 1'b1);
    check("glitch_frame_err", ferr0, 1'b0);

    // Reset in the middle of a frame with a second byte queued.
    write_byte(0, 8'h12);
    write_byte(0, 8'h34);
    repeat (30) @(negedge clk);
    check("tx_in_start_bit", tx0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("tx_forced_high", tx0, 1'b1);
    check("tx_full_after_rst", tx_full0, 1'b0);
    reset = 1'b0;
    cnt = 0;
    for (int j = 0; j < 800; j++) begin
      if (tx0 !== 1'b1) cnt++;
      @(negedge clk);
    end
    check("tx_silent_after_rst", cnt, 0);

    // Activity LED on one unread byte, then freeze after the pop.
    do_reset();
    check("act_led_rst", led0, 1'b0);
    sb_q.push_back(8'h5A);
    fork
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      begin
        w = 0;
        while (rx_empty0 && w < 1000) begin @(negedge clk); w++; end
        check("act_byte_arrived", rx_empty0, 1'b0);
        for (int n = 0; n < 40; n++) begin
          check($sformatf("act_led_n%0d", n), led0, n[3]);
          @(negedge clk);
        end
        pop_check(0, "act_pop");
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
          if (led0 === 1'b1) cnt++;
          @(negedge clk);
        end
        check("act_led_frozen", cnt, 30);
      end
    join

    // Even-parity instance: TX looped into RX externally.
    lb_sel = 1'b1;
    do_reset();
    sb_q.push_back(8'h3C);
    write_byte(1, 8'h3C);
    sb_q.push_back(8'h81);
    write_byte(1, 8'h81);
    check("lb_tx_full", tx_full1, 1'b0);
    repeat (1600) @(negedge clk);
    check("lb_rx_avail", rx_empty1, 1'b0);
    pop_check(1, "lb_pop0");
    pop_check(1, "lb_pop1");
    check("lb_rx_drained", rx_empty1, 1'b1);
    check("lb_errors", {ferr1, perr1, ovr1}, 3'b000);
    check("lb_act_led", led1, 1'b0);

    // Wrong parity bit is flagged but the byte is still stored.
    lb_sel = 1'b0;
    repeat (20) @(negedge clk);
    sb_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    check("par_bad_flag", perr1, 1'b1);
    check("par_bad_ferr", ferr1, 1'b0);
    pop_check(1, "par_bad_data");
    clr_errors();
    check("par_cleared", perr1, 1'b0);
    sb_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check("par_good_flag", perr1, 1'b0);
    pop_check(1, "par_good_data");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
